// File: rtl/lu_recompose.sv
// ---------------------------------------------------------------------------
// lu_recompose
//   Rebuilds A = L*U from the L and U factors of an NxN LU decomposition.
//   Used as the inverse-direction check engine: the host writes the factors,
//   pulses start, waits for finish and reads A back.
//
//   A single multiplier is time-shared. The FSM visits every A[i][j] in
//   row-major order. For each element it spends min(i,j)+1 cycles
//   accumulating L[i][k]*U[k][j]. All arithmetic wraps modulo 2^DW.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   wr       write strobe for L/U storage (ignored while busy)
//   wr_sel   0 = write L, 1 = write U
//   wr_addr  element index row*N+col (indices >= N*N are dropped)
//   wr_data  element value
//   start    single-cycle pulse that starts recomposition
//   rd_addr  A element index row*N+col
//   rd_data  A[rd_addr], registered, one cycle latency (0 if out of range)
//   busy     high while the MAC sequence runs
//   finish   high once A is complete, held until the next start or write
// ---------------------------------------------------------------------------
module lu_recompose #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          finish
);

    localparam int NN    = N * N;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    // Storage is sized to the full address space so every address is a
    // legal index; only the first N*N locations are ever written.
    logic [DW-1:0] l_mem [0:DEPTH-1];
    logic [DW-1:0] u_mem [0:DEPTH-1];
    logic [DW-1:0] a_mem [0:DEPTH-1];

    state_t        state_reg, state_next;
    logic [CW-1:0] i_reg, i_next;
    logic [CW-1:0] j_reg, j_next;
    logic [CW-1:0] k_reg, k_next;
    logic [DW-1:0] acc_reg, acc_next;
    logic [DW-1:0] rd_data_reg;

    logic          a_we;
    logic [AW-1:0] a_waddr;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          l_we;
    logic          u_we;
    logic [CW-1:0] k_last;
    logic [DW-1:0] l_val;
    logic [DW-1:0] u_val;
    logic [DW-1:0] prod;
    logic [DW-1:0] sum;

    // Masked view of the current L row and U column.
    logic [DW-1:0] l_row [0:N-1];
    logic [DW-1:0] u_col [0:N-1];

    function automatic logic [AW-1:0] elem_idx(input logic [CW-1:0] r,
                                               input logic [CW-1:0] c);
        return AW'(r) * AW'(N) + AW'(c);
    endfunction

    // Range checks use one extra bit so N*N == 2^AW still compares correctly.
    assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(NN));
    assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(NN));

    // Writes are locked out while the MAC sequence is reading the factors.
    assign l_we = wr && (state_reg != S_MAC) && wr_in_range && !wr_sel;
    assign u_we = wr && (state_reg != S_MAC) && wr_in_range &&  wr_sel;

    // Triangular structure is imposed on read, so whatever the host stored at
    // masked positions (L upper, L diagonal, U lower) never reaches the MAC.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign l_row[gi] = (CW'(gi) == i_reg) ? DW'(1) :
                               (CW'(gi) >  i_reg) ? '0     :
                               l_mem[elem_idx(i_reg, CW'(gi))];
            assign u_col[gi] = (CW'(gi) >  j_reg) ? '0 :
                               u_mem[elem_idx(CW'(gi), j_reg)];
        end
    endgenerate

    assign l_val   = l_row[k_reg];
    assign u_val   = u_col[k_reg];
    assign prod    = l_val * u_val;
    assign sum     = acc_reg + prod;
    assign k_last  = (i_reg < j_reg) ? i_reg : j_reg;
    assign a_waddr = elem_idx(i_reg, j_reg);

    // Next-state and datapath control.
    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        acc_next   = acc_reg;
        a_we       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // A simultaneous write takes priority over start.
                if (start && !wr) begin
                    state_next = S_MAC;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    acc_next   = '0;
                end
            end

            S_MAC: begin
                if (k_reg < k_last) begin
                    acc_next = sum;
                    k_next   = k_reg + 1'b1;
                end else begin
                    // Final term of this dot product: commit and move on.
                    a_we     = 1'b1;
                    acc_next = '0;
                    k_next   = '0;
                    if (j_reg == LAST_IDX) begin
                        j_next = '0;
                        if (i_reg == LAST_IDX) begin
                            i_next     = '0;
                            state_next = S_DONE;
                        end else begin
                            i_next = i_reg + 1'b1;
                        end
                    end else begin
                        j_next = j_reg + 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (wr) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next = S_MAC;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    acc_next   = '0;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // Control state and the registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            acc_reg     <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            i_reg       <= i_next;
            j_reg       <= j_next;
            k_reg       <= k_next;
            acc_reg     <= acc_next;
            rd_data_reg <= rd_in_range ? a_mem[rd_addr] : '0;
        end
    end

    // Matrix storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (l_we) begin
            l_mem[wr_addr] <= wr_data;
        end
        if (u_we) begin
            u_mem[wr_addr] <= wr_data;
        end
        if (a_we) begin
            a_mem[a_waddr] <= sum;
        end
    end

    assign rd_data = rd_data_reg;
    assign busy    = (state_reg == S_MAC);
    assign finish  = (state_reg == S_DONE);

endmodule

// File: tb/tb_lu_recompose.sv
module tb_lu_recompose;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NN = N * N;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          wr      = 1'b0;
    logic          wr_sel  = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          finish;

    // Second instance built for N=2.
    logic          wr2      = 1'b0;
    logic          wr_sel2  = 1'b0;
    logic [1:0]    wr_addr2 = '0;
    logic [DW-1:0] wr_data2 = '0;
    logic          start2   = 1'b0;
    logic [1:0]    rd_addr2 = '0;
    logic [DW-1:0] rd_data2;
    logic          busy2;
    logic          finish2;

    lu_recompose #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .finish(finish)
    );

    lu_recompose #(.N(2), .DW(DW), .AW(2)) dut2 (
        .clk(clk), .reset(reset), .wr(wr2), .wr_sel(wr_sel2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .start(start2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .finish(finish2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Shadow of what the host has stored (raw, unmasked).
    logic [DW-1:0] ml [NN];
    logic [DW-1:0] mu [NN];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mathematical L and U: unit lower triangular and upper triangular.
    function automatic logic [DW-1:0] lm(input int r, input int c);
        if (r == c) return 1;
        if (c > r)  return 0;
        return ml[r*N+c];
    endfunction

    function automatic logic [DW-1:0] um(input int r, input int c);
        if (r > c) return 0;
        return mu[r*N+c];
    endfunction

    function automatic logic [DW-1:0] ref_a(input int r, input int c);
        logic [DW-1:0] s = 0;
        for (int k = 0; k < N; k++) s = s + lm(r, k) * um(k, c);
        return s;
    endfunction

    function automatic int ref_cycles();
        int t = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t += ((r < c) ? r : c) + 1;
        return t;
    endfunction

    task automatic wr_el(input logic sel, input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        wr = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
        @(negedge clk);
        wr = 1'b0;
        if (addr < NN) begin
            if (sel) mu[addr] = d;
            else     ml[addr] = d;
        end
    endtask

    // Pulse start and count cycles with busy high. Optionally inject a write
    // (to U[0][0]) or a second start at a given busy cycle.
    task automatic run(input string tag, input int wr_at, input int st_at);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 200) begin
            cyc++;
            wr    = (cyc == wr_at);
            start = (cyc == st_at);
            if (cyc == wr_at) begin
                wr_sel = 1'b1; wr_addr = '0; wr_data = 32'hdead_beef;
            end
            @(negedge clk);
        end
        wr = 1'b0;
        start = 1'b0;
        check_val({tag, "_cycles"}, cyc, ref_cycles());
        check_val({tag, "_finish"}, finish, 1);
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < NN; a++) begin
            @(negedge clk);
            rd_addr = AW'(a);
            @(negedge clk);
            check_val($sformatf("%s_A%0d", tag, a), rd_data, ref_a(a / N, a % N));
        end
        @(negedge clk);
        rd_addr = AW'(NN);
        @(negedge clk);
        check_val({tag, "_oob"}, rd_data, 0);
    endtask

    task automatic check_const(input string tag);
        logic [DW-1:0] exp_a [NN] = '{2, 1, 1, 4, 5, 4, 8, 13, 15};
        for (int a = 0; a < NN; a++) begin
            @(negedge clk);
            rd_addr = AW'(a);
            @(negedge clk);
            check_val($sformatf("%s_A%0d", tag, a), rd_data, exp_a[a]);
        end
    endtask

    task automatic wr2_el(input logic sel, input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        wr2 = 1'b1; wr_sel2 = sel; wr_addr2 = 2'(addr); wr_data2 = d;
        @(negedge clk);
        wr2 = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] tl [NN] = '{1, 0, 0, 2, 1, 0, 4, 3, 1};
        logic [DW-1:0] tu [NN] = '{2, 1, 1, 0, 3, 2, 0, 0, 5};
        logic [DW-1:0] l2 [4]  = '{1, 0, 3, 1};
        logic [DW-1:0] u2 [4]  = '{2, 5, 0, 4};
        logic [DW-1:0] a2 [4]  = '{2, 5, 6, 19};
        int cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_finish", finish, 0);
        check_val("rst_rd_data", rd_data, 0);
        reset = 1'b1;

        // Reference example
        for (int a = 0; a < NN; a++) begin
            wr_el(1'b0, a, tl[a]);
            wr_el(1'b1, a, tu[a]);
        end
        run("basic", -1, -1);
        check_const("basic");

        // Writes at masked positions must not change A; write in DONE drops finish
        wr_el(1'b0, 2, 99);
        check_val("wr_done_finish", finish, 0);
        wr_el(1'b0, 4, 7);
        wr_el(1'b1, 6, 55);
        wr_el(1'b0, 40, 123);   // out of range, dropped
        run("mask", -1, -1);
        check_const("mask");
        check_all("mask_model");

        // Modular wrap
        for (int a = 0; a < NN; a++) wr_el(1'b1, a, 0);
        wr_el(1'b1, 0, 2);
        wr_el(1'b0, 3, 32'h8000_0000);
        run("wrap", -1, -1);
        @(negedge clk); rd_addr = 3;
        @(negedge clk);
        check_val("wrap_A10", rd_data, 0);
        check_all("wrap");

        // start together with wr: write wins, no computation begins
        wr_el(1'b0, 0, 5);
        @(negedge clk);
        wr = 1'b1; start = 1'b1; wr_sel = 1'b1; wr_addr = 4; wr_data = 9;
        @(negedge clk);
        wr = 1'b0; start = 1'b0;
        mu[4] = 9;
        check_val("start_wr_busy", busy, 0);
        @(negedge clk);
        check_val("start_wr_busy2", busy, 0);
        run("start_wr", -1, -1);
        check_all("start_wr");

        // Randomized matrices, with a write and a start injected while busy
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < NN; a++) begin
                wr_el(1'b0, a, $urandom);
                wr_el(1'b1, a, (it < 2) ? $urandom_range(0, 50) : $urandom);
            end
            run($sformatf("rand%0d", it), (it == 0) ? 3 : -1, (it == 1) ? 5 : -1);
            check_all($sformatf("rand%0d", it));
        end

        // Reset in the middle of MAC
        @(negedge clk);
        rd_addr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_finish", finish, 0);
        check_val("midrst_rd_data", rd_data, 0);
        @(negedge clk);
        reset = 1'b1;
        run("after_rst", -1, -1);
        check_all("after_rst");

        // N=2 instance
        for (int a = 0; a < 4; a++) begin
            wr2_el(1'b0, a, l2[a]);
            wr2_el(1'b1, a, u2[a]);
        end
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_val("n2_cycles", cyc, 5);
        check_val("n2_finish", finish2, 1);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            rd_addr2 = 2'(a);
            @(negedge clk);
            check_val($sformatf("n2_A%0d", a), rd_data2, a2[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lu_recompose.md
Name: lu_recompose

Overview:
- Consumes the L and U factors produced by the team's LU decomposition block and rebuilds A = L*U.
- Serves as the inverse-direction check engine: the bench or host writes L and U in, pulses start, and reads back the reconstructed A for comparison against the original matrix.
- Uses one multiplier, sequenced by an FSM, with one multiply-accumulate per cycle.

Parameters:
N, 3, matrix dimension (NxN); supported range 2..8
DW, 32, element width in bits
AW, 6, address width; must satisfy 2^AW >= N*N

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
wr  input  1  write strobe for the L/U factor storage
wr_sel  input  1  0 = write L, 1 = write U
wr_addr  input  AW  element index, row*N+col
wr_data  input  DW  element value
start  input  1  single-cycle pulse that begins recomposition
rd_addr  input  AW  A element index, row*N+col
rd_data  output  DW  A[rd_addr]; registered, 1-cycle latency
busy  output  1  high while computing
finish  output  1  high once A is complete; held until the next start

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; busy=0, finish=0, rd_data=0; accumulator and i/j/k counters clear to 0.
  - L, U and A storage are not cleared.
- Writes:
  - Accepted only when busy=0.
  - A write with wr_addr >= N*N is dropped.
  - A write in IDLE or DONE clears finish on the next edge.
- Triangular masking, applied when operands are read, not when they are stored:
  - L diagonal is forced to 1; L entries with col > row are treated as 0.
  - U entries with row > col are treated as 0.
  - Stored values at masked positions have no effect.
- FSM states: IDLE, MAC, DONE.
  - IDLE -> MAC on start=1 and wr=0. start together with wr: the write wins and start is ignored. On entry: i=j=k=0, acc=0, busy=1.
  - MAC, per cycle:
    - Compute p = L[i][k]*U[k][j], truncated to DW bits.
    - If k < min(i,j): acc <= acc+p, k <= k+1.
    - Else: A[i][j] <= acc+p, acc <= 0, k <= 0, and advance j; when j wraps (j=N-1 -> 0), advance i.
    - After A[N-1][N-1] is written, go to DONE.
  - DONE: busy=0, finish=1. Stays in DONE until start (-> MAC, finish cleared the same edge) or wr (-> IDLE).
  - start while in MAC is ignored.
- Latency:
  - MAC cycles = sum over i,j of (min(i,j)+1). This is 5 for N=2 and 14 for N=3.
  - finish rises on the edge after the last MAC cycle.
- Arithmetic:
  - Products and sums wrap modulo 2^DW.
  - The low DW bits are identical for signed and unsigned interpretation, so no sign handling is needed.
- Read port:
  - rd_data <= A[rd_addr] every cycle, including while busy; during busy it returns current contents, whether stale or already updated.
  - rd_addr >= N*N returns 0.
- Reset mid-MAC: computation aborts and busy, finish and counters clear. A holds a partial result; a new start recomputes it fully.

Test Plan:
- N=3: L=[[1,0,0],[2,1,0],[4,3,1]], U=[[2,1,1],[0,3,2],[0,0,5]], start -> busy for exactly 14 cycles, then finish=1; A reads back [[2,1,1],[4,5,4],[8,13,15]] with rd_data one cycle after rd_addr.
- Masking: same as above, plus L[0][2]=99, L[1][1]=7, U[2][0]=55 -> A is unchanged, [[2,1,1],[4,5,4],[8,13,15]].
- Wrap: L[1][0]=32'h80000000, U[0][0]=2, all other U=0 -> A[1][0]=0, with no flag or error raised.
- Protocol:
  - A write during busy is ignored (the result matches the pre-write matrices).
  - start during MAC is ignored (total cycle count stays 14).
  - A wr in DONE drops finish the next cycle.
  - start and wr in the same cycle performs the write and busy stays 0.
- Reset mid-operation: assert reset=0 at MAC cycle 6 -> busy=0, finish=0 and rd_data=0 immediately. After release, start yields the correct full A in 14 cycles.
- N=2 build: L=[[1,0],[3,1]], U=[[2,5],[0,4]] -> 5 MAC cycles; A=[[2,5],[6,19]].
